// File: rtl/encoder_8to3_seq_if.sv
// Handshake bundle for encoder_8to3_seq.
// The producer side offers an 8-bit request vector with valid/ready.
// The consumer side receives one index per transfer with valid/ready.
interface encoder_8to3_seq_if;
    logic       enable;
    logic       in_valid;
    logic [7:0] in;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out;
    logic       out_last;
    logic [3:0] out_remain;
    logic       err_zero;

    // Environment side: drives requests and consumer readiness.
    modport master (
        output enable,
        output in_valid,
        output in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  out_last,
        input  out_remain,
        input  err_zero
    );

    // Encoder side.
    modport slave (
        input  enable,
        input  in_valid,
        input  in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output out_last,
        output out_remain,
        output err_zero
    );
endinterface

// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 priority encoder.
// An accepted request vector is captured into a pending register. The
// pending set bits are then emitted one index per transfer, lowest index
// first. A new vector is only taken once every bit of the previous one has
// been handed to the consumer. An all-zero vector raises a one-cycle
// err_zero pulse and produces no output.
module encoder_8to3_seq (
    input  logic                clk,
    input  logic                rst,
    encoder_8to3_seq_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pend_q;
    logic [7:0] pend_d;
    logic       err_zero_q;
    logic       err_zero_d;

    // Combinational views of the pending register.
    logic [7:0] lowest_oh;
    logic [2:0] lowest_idx;
    logic [3:0] pend_count;
    logic       in_ready_c;
    logic       accept;
    logic       emit_c;
    logic       last_c;

    // One-hot of the lowest set pending bit. Each bit looks only at the
    // bits below it through a constant mask. This avoids a ripple chain
    // that would feed back into the same vector.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lowest
            localparam logic [7:0] BELOW_MASK = 8'((9'd1 << gi) - 9'd1);
            assign lowest_oh[gi] = pend_q[gi] & ~(|(pend_q & BELOW_MASK));
        end
    endgenerate

    // Encode the one-hot into a binary index. Bit b of the index is set
    // when the hot position has bit b set.
    assign lowest_idx = {|(lowest_oh & 8'hF0),
                         |(lowest_oh & 8'hCC),
                         |(lowest_oh & 8'hAA)};

    // Popcount of the pending bits. This count includes the index currently shown.
    always_comb begin
        pend_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pend_count = pend_count + {3'b000, pend_q[i]};
        end
    end

    assign emit_c     = (state_q == EMIT);
    assign last_c     = emit_c && (pend_count == 4'd1);
    assign in_ready_c = (state_q == IDLE) && bus.enable;
    assign accept     = bus.in_valid && in_ready_c;

    // Next-state and pending-register update.
    // Inputs on the request side are ignored outside IDLE, so toggling
    // enable or in_valid mid-emission has no effect.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        err_zero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in != 8'h00) begin
                        pend_d  = bus.in;
                        state_d = EMIT;
                    end else begin
                        err_zero_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pend_d = pend_q & ~lowest_oh;
                    if (last_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 8'h00;
            end
        endcase
    end

    // State, pending and error-pulse registers. Reset clears everything,
    // so no stale index can appear after it is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= 8'h00;
            err_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            err_zero_q <= err_zero_d;
        end
    end

    // Outputs come straight from the registers, so they clear as soon as
    // reset is asserted. They are forced to zero while the FSM is idle.
    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = emit_c;
    assign bus.out        = emit_c ? lowest_idx : 3'd0;
    assign bus.out_remain = emit_c ? pend_count : 4'd0;
    assign bus.out_last   = last_c;
    assign bus.err_zero   = err_zero_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Directed testbench for encoder_8to3_seq.
// A table of vectors is run under continuous out_ready. Hand-written
// sequences then cover backpressure, zero vectors, enable and reset.
module tb_encoder_8to3_seq;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    encoder_8to3_seq_if bus ();

    encoder_8to3_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector with its expected index sequence, one nibble per index, lowest nibble first.
    typedef struct {
        logic [7:0]  vec;
        int          n;
        logic [31:0] seq;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, "_out"},        32'(bus.out),        32'd0);
        chk({tag, "_out_last"},   32'(bus.out_last),   32'd0);
        chk({tag, "_out_remain"}, 32'(bus.out_remain), 32'd0);
        chk({tag, "_err_zero"},   32'(bus.err_zero),   32'd0);
    endtask

    task automatic chk_emit(input string tag, input int idx, input int remain, input int last);
        chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd1);
        chk({tag, "_out"},        32'(bus.out),        32'(idx));
        chk({tag, "_out_remain"}, 32'(bus.out_remain), 32'(remain));
        chk({tag, "_out_last"},   32'(bus.out_last),   32'(last));
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        tbl[0] = '{vec: 8'h04, n: 1, seq: 32'h0000_0002};
        tbl[1] = '{vec: 8'hA1, n: 3, seq: 32'h0000_0750};
        tbl[2] = '{vec: 8'h0C, n: 2, seq: 32'h0000_0032};
        tbl[3] = '{vec: 8'h80, n: 1, seq: 32'h0000_0007};
        tbl[4] = '{vec: 8'h01, n: 1, seq: 32'h0000_0000};
        tbl[5] = '{vec: 8'hFF, n: 8, seq: 32'h7654_3210};
        tbl[6] = '{vec: 8'h55, n: 4, seq: 32'h0000_6420};
        tbl[7] = '{vec: 8'h81, n: 2, seq: 32'h0000_0070};

        // Reset state
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = 8'h00;
        bus.out_ready = 1'b1;
        step();
        step();
        chk_idle_outputs("reset");
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("release_enable0_in_ready", 32'(bus.in_ready), 32'd0);
        bus.enable = 1'b1;
        #1;
        chk("release_enable1_in_ready", 32'(bus.in_ready), 32'd1);

        // Table-driven vectors, continuous out_ready
        for (int t = 0; t < 8; t++) begin
            bus.enable    = 1'b1;
            bus.out_ready = 1'b1;
            bus.in        = tbl[t].vec;
            bus.in_valid  = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready_pre", t), 32'(bus.in_ready), 32'd1);
            step();
            bus.in_valid = 1'b0;
            bus.in       = 8'h00;
            for (int k = 0; k < tbl[t].n; k++) begin
                chk_emit($sformatf("tbl%0d_k%0d", t, k),
                         int'(tbl[t].seq[4*k +: 3]),
                         tbl[t].n - k,
                         (k == tbl[t].n - 1) ? 1 : 0);
                chk($sformatf("tbl%0d_k%0d_in_ready", t, k), 32'(bus.in_ready), 32'd0);
                step();
            end
            chk($sformatf("tbl%0d_done_out_valid", t), 32'(bus.out_valid), 32'd0);
            chk($sformatf("tbl%0d_done_in_ready", t), 32'(bus.in_ready), 32'd1);
            $display("vector %0d in=%02h emitted %0d indices", t, tbl[t].vec, tbl[t].n);
        end

        // Zero vector
        bus.in       = 8'h00;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("zero_err_zero", 32'(bus.err_zero), 32'd1);
        chk("zero_out_valid", 32'(bus.out_valid), 32'd0);
        chk("zero_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("zero_err_zero_gone", 32'(bus.err_zero), 32'd0);
        chk("zero_out_valid_after", 32'(bus.out_valid), 32'd0);
        $display("zero vector: err_zero pulse checked");

        // Backpressure on 8'h82
        bus.out_ready = 1'b0;
        bus.in        = 8'h82;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_emit($sformatf("bp_hold%0d", c), 1, 2, 0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk_emit("bp_release", 1, 2, 0);
        step();
        chk_emit("bp_second", 7, 1, 1);
        step();
        chk("bp_done_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_done_in_ready", 32'(bus.in_ready), 32'd1);
        $display("backpressure vector 82 checked");

        // enable=0 blocks acceptance
        bus.enable   = 1'b0;
        bus.in       = 8'h10;
        bus.in_valid = 1'b1;
        #1;
        chk("en0_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        step();
        chk("en0_out_valid", 32'(bus.out_valid), 32'd0);
        chk("en0_err_zero", 32'(bus.err_zero), 32'd0);
        bus.in_valid = 1'b0;
        $display("enable low: no accept checked");

        // enable dropped mid-emission of 8'h0C
        bus.enable   = 1'b1;
        bus.in       = 8'h0C;
        bus.in_valid = 1'b1;
        step();
        bus.enable   = 1'b0;
        bus.in       = 8'hF0;
        #1;
        chk_emit("endrop_first", 2, 2, 0);
        step();
        chk_emit("endrop_second", 3, 1, 1);
        step();
        chk("endrop_done_out_valid", 32'(bus.out_valid), 32'd0);
        chk("endrop_done_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.enable   = 1'b1;
        $display("enable drop mid-emit checked");

        // Reset during the emission of 8'hFF
        bus.in       = 8'hFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk_emit("rstmid_idx0", 0, 8, 0);
        step();
        chk_emit("rstmid_idx1", 1, 7, 0);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rstmid_async");
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rstmid_post%0d_out_valid", c), 32'(bus.out_valid), 32'd0);
        end
        bus.in       = 8'h04;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk_emit("rstmid_new", 2, 1, 1);
        step();
        chk("rstmid_new_done", 32'(bus.out_valid), 32'd0);
        $display("reset mid-emit checked");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/encoder_8to3_seq.md
ENCODER_8TO3_SEQ -- requirements
Module: encoder_8to3_seq

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be: none; input width fixed at 8 bits, index width fixed at 3 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 enable  input  1  when 0, the block accepts no new vector; an in-progress emission continues.
REQ-006 in_valid  input  1  the producer presents a vector on in.
REQ-007 in  input  8  request vector; any number of bits may be set.
REQ-008 in_ready  output  1  the block can accept a vector this cycle.
REQ-009 out_valid  output  1  out, out_last and out_remain are valid.
REQ-010 out_ready  input  1  the consumer takes the current index this cycle.
REQ-011 out  output  3  index of the lowest still-pending set bit.
REQ-012 out_last  output  1  the current index is the final one of the vector.
REQ-013 out_remain  output  4  pending-bit count, including the current index (1..8).
REQ-014 err_zero  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-015 The block SHALL have a two-state FSM: IDLE and EMIT, plus an 8-bit pending register pend.
REQ-016 in_ready SHALL equal (state==IDLE) AND enable, combinationally; no vector is accepted in EMIT.
REQ-017 Accept event: in_valid AND in_ready at a rising clk edge.
REQ-018 On accept with in!=0: pend<=in, state<=EMIT; out_valid SHALL be 1 in the next cycle (latency 1).
REQ-019 On accept with in==0: pend unchanged, state stays IDLE, err_zero=1 for exactly the next cycle, no out_valid.
REQ-020 out_valid SHALL be 1 exactly when state==EMIT.
REQ-021 In EMIT, out SHALL be the index of the lowest set bit of pend; lower index = higher priority.
REQ-022 In EMIT, out_remain SHALL be popcount(pend), and out_last SHALL be (out_remain==1).
REQ-023 In IDLE, out, out_last and out_remain SHALL be 0.
REQ-024 Transfer event: out_valid AND out_ready at a rising edge; this clears bit out of pend.
REQ-025 A transfer with out_last=1 SHALL return the FSM to IDLE; in_ready may then be 1 in the following cycle.
REQ-026 While out_ready=0, out, out_last and out_remain SHALL stay stable (no bit is dropped or skipped).
REQ-027 A vector with n set bits SHALL take n consecutive cycles under continuous out_ready, plus 1 IDLE cycle before the next accept.
REQ-028 A change of enable or in_valid during EMIT SHALL have no effect on emission.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, pend=0, out_valid=0, out=0, out_last=0, out_remain=0, err_zero=0.
REQ-030 A reset during EMIT SHALL discard all pending bits; after reset is released, no stale index is emitted.
REQ-031 in_ready SHALL be 1 in the first cycle after release only if enable=1.

Verification
REQ-032 in=8'b0000_0100 accepted, out_ready=1 -> next cycle: out_valid=1, out=2, out_last=1, out_remain=1; following cycle: out_valid=0, in_ready=1.
REQ-033 in=8'b1010_0001, out_ready=1 -> out is 0, 5, 7 on consecutive cycles; out_remain is 3, 2, 1; out_last=1 only with 7.
REQ-034 in=8'b1000_0010, out_ready=0 for 3 cycles -> out=1 held stable with out_remain=2; then out_ready=1 -> 1, then 7 with out_last=1.
REQ-035 in=8'h00 accepted -> err_zero=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-036 enable=0 with in_valid=1 -> in_ready=0, nothing accepted; enable dropped mid-EMIT of 8'h0C -> still emits 2, then 3.
REQ-037 in=8'hFF accepted, rst asserted after index 0 is transferred -> all outputs are 0 immediately; after release there is no out_valid until a new accept.
